// File: rtl/fpu_division_sequencer.sv
// Stage-2 stall controller for the iterative divide/sqrt unit: holds stage 2
// while the datapath runs one load cycle, N iterations, then a done handshake.
module fpu_division_sequencer #(
  parameter int DIV_ITERATIONS  = 25,
  parameter int SQRT_ITERATIONS = 25,
  parameter int COUNT_WIDTH     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   fpu_stage2_division_op,
  input  logic                   fpu_stage2_normal_op,
  input  logic                   fpu_stage2_division_mode,
  output logic                   stall,
  output logic                   division_load,
  output logic                   division_iterate,
  output logic [COUNT_WIDTH-1:0] iteration_count,
  output logic                   division_done,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITERATE,
    DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] DIV_LAST  = COUNT_WIDTH'(DIV_ITERATIONS - 1);
  localparam logic [COUNT_WIDTH-1:0] SQRT_LAST = COUNT_WIDTH'(SQRT_ITERATIONS - 1);

  state_t                 state;
  logic                   mode_q;
  logic                   start;
  logic [COUNT_WIDTH-1:0] last_count;

  // reset is folded into start so the stall path is quiet while reset is held
  always_comb begin
    start      = reset & fpu_stage2_division_op & fpu_stage2_normal_op & ~stall_in;
    last_count = mode_q ? SQRT_LAST : DIV_LAST;
  end

  always_comb begin
    stall = stall_in;
    case (state)
      IDLE:          stall = stall_in | start;
      LOAD, ITERATE: stall = 1'b1;
      DONE:          stall = stall_in;
      default:       stall = stall_in;
    endcase
  end

  // Pulse outputs are registered alongside the state they decode, so each one
  // is set on the edge that enters its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mode_q           <= 1'b0;
      iteration_count  <= '0;
      division_load    <= 1'b0;
      division_iterate <= 1'b0;
      division_done    <= 1'b0;
      busy             <= 1'b0;
    end else begin
      division_load    <= 1'b0;
      division_iterate <= 1'b0;
      division_done    <= 1'b0;
      case (state)
        IDLE: begin
          iteration_count <= '0;
          if (start) begin
            state         <= LOAD;
            division_load <= 1'b1;
            busy          <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          mode_q           <= fpu_stage2_division_mode;
          iteration_count  <= '0;
          state            <= ITERATE;
          division_iterate <= 1'b1;
        end
        ITERATE: begin
          if (iteration_count == last_count) begin
            state         <= DONE;
            division_done <= 1'b1;
          end else begin
            iteration_count  <= iteration_count + 1'b1;
            division_iterate <= 1'b1;
          end
        end
        DONE: begin
          if (stall_in) begin
            division_done <= 1'b1;
          end else begin
            state           <= IDLE;
            iteration_count <= '0;
            busy            <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          iteration_count <= '0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_division_sequencer.sv
// Bench for fpu_division_sequencer: two instances (25/13 and 1/32 iterations)
// checked every cycle against a cycle-offset reference model plus directed checks.
module tb_fpu_division_sequencer;
  localparam int CW = 5;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic stall_in  = 1'b0;
  logic div_op    = 1'b0;
  logic normal_op = 1'b0;
  logic mode      = 1'b0;

  logic [1:0]    stall_v, load_v, iter_v, done_v, busy_v;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: t = cycles elapsed since the op was accepted
  // (0 = idle, 1 = load, 2..limit+1 = iterations, beyond = done).
  int lim [2][2] = '{'{25, 13}, '{1, 32}};
  int t   [2]    = '{0, 0};
  bit ml  [2]    = '{1'b0, 1'b0};

  bit meas = 1'b0;
  int st_cnt, it_cnt, dn_cnt;
  int load_cyc[$];
  int done_cyc[$];

  always #5 clk = ~clk;

  fpu_division_sequencer #(.DIV_ITERATIONS(25), .SQRT_ITERATIONS(13), .COUNT_WIDTH(CW)) u_a (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .fpu_stage2_division_op(div_op), .fpu_stage2_normal_op(normal_op),
    .fpu_stage2_division_mode(mode),
    .stall(stall_v[0]), .division_load(load_v[0]), .division_iterate(iter_v[0]),
    .iteration_count(cnt_a), .division_done(done_v[0]), .busy(busy_v[0]));

  fpu_division_sequencer #(.DIV_ITERATIONS(1), .SQRT_ITERATIONS(32), .COUNT_WIDTH(CW)) u_b (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .fpu_stage2_division_op(div_op), .fpu_stage2_normal_op(normal_op),
    .fpu_stage2_division_mode(mode),
    .stall(stall_v[1]), .division_load(load_v[1]), .division_iterate(iter_v[1]),
    .iteration_count(cnt_b), .division_done(done_v[1]), .busy(busy_v[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int i);
    bit start;
    int l;
    logic [31:0] e_st, e_ld, e_it, e_dn, e_bz, e_ct, o_ct;
    start = reset && div_op && normal_op && !stall_in;
    if (!reset) t[i] = 0;
    l = ml[i] ? lim[i][1] : lim[i][0];
    e_ld = 0; e_it = 0; e_dn = 0;
    if (t[i] == 0) begin
      e_st = 32'(stall_in | start); e_bz = 0; e_ct = 0;
    end else if (t[i] == 1) begin
      e_st = 1; e_ld = 1; e_bz = 1; e_ct = 0;
    end else if (t[i] <= l + 1) begin
      e_st = 1; e_it = 1; e_bz = 1; e_ct = 32'(t[i] - 2);
    end else begin
      e_st = 32'(stall_in); e_dn = 1; e_bz = 1; e_ct = 32'(l - 1);
    end
    o_ct = (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
    chk($sformatf("u%0d.stall@%0d", i, cyc),   32'(stall_v[i]), e_st);
    chk($sformatf("u%0d.load@%0d", i, cyc),    32'(load_v[i]),  e_ld);
    chk($sformatf("u%0d.iterate@%0d", i, cyc), 32'(iter_v[i]),  e_it);
    chk($sformatf("u%0d.done@%0d", i, cyc),    32'(done_v[i]),  e_dn);
    chk($sformatf("u%0d.busy@%0d", i, cyc),    32'(busy_v[i]),  e_bz);
    chk($sformatf("u%0d.count@%0d", i, cyc),   o_ct,            e_ct);
  endtask

  task automatic update_model(input int i);
    int l;
    l = ml[i] ? lim[i][1] : lim[i][0];
    if (!reset)                t[i] = 0;
    else if (t[i] == 0)        t[i] = (div_op && normal_op && !stall_in) ? 1 : 0;
    else if (t[i] == 1)        begin ml[i] = mode; t[i] = 2; end
    else if (t[i] <= l + 1)    t[i] = t[i] + 1;
    else if (!stall_in)        t[i] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model(0);
    check_model(1);
    if (meas) begin
      if (done_cyc.size() == 0 && !done_v[0]) begin
        if (stall_v[0]) st_cnt++;
        if (iter_v[0])  it_cnt++;
      end
      if (done_v[0]) begin dn_cnt++; done_cyc.push_back(cyc); end
      if (load_v[0]) load_cyc.push_back(cyc);
    end
    @(posedge clk);
    update_model(0);
    update_model(1);
    cyc++;
    #1;
  endtask

  task automatic clear_meas();
    st_cnt = 0; it_cnt = 0; dn_cnt = 0;
    load_cyc.delete();
    done_cyc.delete();
    meas = 1'b1;
  endtask

  task automatic drain();
    int k;
    div_op = 1'b0;
    stall_in = 1'b0;
    k = 0;
    while (busy_v != 2'b00 && k < 100) begin tick(); k++; end
    chk("drain_idle", 32'(busy_v), 0);
  endtask

  initial begin
    int k, rel_cyc;

    // Reset held with a valid division present: nothing may start.
    #1 reset = 1'b0;
    div_op = 1'b1; normal_op = 1'b1; mode = 1'b0; stall_in = 1'b0;
    repeat (3) tick();
    chk("rst_stall", 32'(stall_v), 0);
    chk("rst_busy",  32'(busy_v),  0);

    // Default divide followed by a back-to-back second divide.
    reset = 1'b1;
    clear_meas();
    rel_cyc = cyc;
    #1 chk("release_stall", 32'(stall_v[0]), 1);
    k = 0;
    while (done_cyc.size() == 0 && k < 100) begin tick(); k++; end
    k = 0;
    while (load_cyc.size() < 2 && k < 20) begin tick(); k++; end
    chk("div_stall_cycles", 32'(st_cnt), 27);
    chk("div_iter_cycles",  32'(it_cnt), 25);
    chk("div_done_seen",    32'(done_cyc.size()), 1);
    chk("div_load_seen",    32'(load_cyc.size()), 2);
    if (load_cyc.size() == 2 && done_cyc.size() == 1) begin
      chk("load_after_release", 32'(load_cyc[0] - rel_cyc), 1);
      chk("load_to_done",       32'(done_cyc[0] - load_cyc[0]), 26);
      chk("back_to_back_gap",   32'(load_cyc[1] - done_cyc[0]), 2);
    end
    meas = 1'b0;
    drain();

    // Sqrt (13 iterations on u_a); mode flips to divide mid-iteration.
    mode = 1'b1; div_op = 1'b1;
    clear_meas();
    k = 0;
    while (!iter_v[0] && k < 20) begin tick(); k++; end
    mode = 1'b0;
    div_op = 1'b0;
    k = 0;
    while (done_cyc.size() == 0 && k < 100) begin tick(); k++; end
    chk("sqrt_iter_cycles",  32'(it_cnt), 13);
    chk("sqrt_stall_cycles", 32'(st_cnt), 15);
    meas = 1'b0;
    drain();

    // Downstream stall held for 4 cycles from the first done cycle.
    mode = 1'b0; div_op = 1'b1;
    clear_meas();
    k = 0;
    while (!done_v[0] && k < 60) begin tick(); k++; end
    stall_in = 1'b1;
    div_op = 1'b0;
    repeat (4) begin
      tick();
      chk("dstall_count_hold", 32'(cnt_a), 24);
      chk("dstall_done_hold",  32'(done_v[0]), 1);
    end
    stall_in = 1'b0;
    tick();
    chk("dstall_done_cycles", 32'(dn_cnt), 5);
    chk("dstall_back_idle",   32'(busy_v[0]), 0);
    meas = 1'b0;
    drain();

    // Special-case operand: division op present but no iteration needed.
    normal_op = 1'b0; div_op = 1'b1;
    repeat (12) begin
      mode = 1'($urandom);
      stall_in = 1'($urandom);
      tick();
      chk("special_busy", 32'(busy_v), 0);
      chk("special_load", 32'(load_v), 0);
    end

    // Reset mid-iteration abandons the op with no done pulse.
    normal_op = 1'b1; div_op = 1'b1; stall_in = 1'b0; mode = 1'b0;
    k = 0;
    while (cnt_a != CW'(10) && k < 40) begin tick(); k++; end
    chk("reach_count10", 32'(cnt_a), 10);
    reset = 1'b0;
    clear_meas();
    #1 chk("midrst_busy",  32'(busy_v[0]), 0);
    chk("midrst_count", 32'(cnt_a), 0);
    repeat (3) begin
      stall_in = 1'($urandom);
      #1 chk("midrst_stall", 32'(stall_v[0]), 32'(stall_in));
      tick();
    end
    chk("midrst_no_done", 32'(done_cyc.size()), 0);
    meas = 1'b0;
    reset = 1'b1;
    stall_in = 1'b0;

    // Randomized traffic against the model.
    repeat (800) begin
      reset     = ($urandom_range(0, 99) != 0);
      stall_in  = ($urandom_range(0, 3) == 0);
      div_op    = ($urandom_range(0, 3) != 0);
      normal_op = ($urandom_range(0, 4) != 0);
      mode      = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
